sync_fifo: RTL and testbench

- Single-clock first-in/first-out buffer for WIDTH-bit data words with write/read enables and full/empty status.
- Sits between a producer and a consumer in the same clock domain and absorbs rate mismatch up to DEPTH words.
- Read data is registered, so each accepted read presents its word one clock later.

---
 rtl/sync_fifo.sv | 88 ++++++++
 tb/tb_sync_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
//
// The producer and consumer share one clock. Up to DEPTH words of WIDTH bits
// are buffered. A read that is accepted on an edge presents its word on
// data_o after that edge, so the word is visible one clock after the read.
//
// Ports
//   clk          rising-edge clock
//   srst         asynchronous active-high reset (pointers, count, data_o)
//   write_enable write request; accepted only when not full
//   read_enable  read request; accepted only when not empty
//   data_i       write data, captured on an accepted write
//   data_o       registered read data; holds when no read is accepted
//   full         DEPTH words stored
//   empty        no words stored
//   count        number of stored words, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             write_enable,
  input  logic             read_enable,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage is deliberately left out of the reset: stale words are never
  // observable because the pointers define what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra MSB that toggles on each pass through the
  // address range; it distinguishes full from empty when addresses match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Flags come straight from the registered pointers, so they reflect the
  // state left by the most recent edge.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_addr == rd_addr) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // Acceptance uses the pre-edge flags: a read on an empty FIFO is refused
  // even when a write arrives in the same cycle (no fall-through), and a
  // write on a full FIFO is refused even when a read frees a slot.
  assign wr_ok = write_enable && !full;
  assign rd_ok = read_enable && !empty;

  // ---- write stage: storage array ----
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= data_i;
    end
  end

  // ---- pointer / read-data stage ----
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_o <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data_o <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo.
// A queue-based reference model tracks the stored words; after each clock
// edge the DUT outputs are compared with the model on the falling edge.
module tb_sync_fifo;

  localparam int WIDTH = 6;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             srst;
  logic             write_enable;
  logic             read_enable;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             full;
  logic             empty;
  logic [AW:0]      count;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .srst         (srst),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_i       (data_i),
    .data_o       (data_o),
    .full         (full),
    .empty        (empty),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents as a queue plus the last word read.
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_o"}, 32'(data_o), 32'(model_dout));
    check({tag, ".count"},  32'(count),  32'(model_q.size()));
    check({tag, ".full"},   32'(full),   32'(model_q.size() == DEPTH));
    check({tag, ".empty"},  32'(empty),  32'(model_q.size() == 0));
  endtask

  // Drive one cycle of stimulus, advance the model across the rising edge
  // using the occupancy seen before the edge, then compare on the falling edge.
  task automatic cycle(input logic we, input logic re, input logic [WIDTH-1:0] d,
                       input string tag);
    bit can_wr;
    bit can_rd;
    write_enable = we;
    read_enable  = re;
    data_i       = d;
    @(posedge clk);
    if (srst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      can_wr = we && (model_q.size() < DEPTH);
      can_rd = re && (model_q.size() > 0);
      if (can_rd) model_dout = model_q.pop_front();
      if (can_wr) model_q.push_back(d);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Reset pulse asserted between edges: its effect must be visible at once.
  task automatic reset_pulse(input string tag);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    srst = 1'b1;
    model_q.delete();
    model_dout = '0;
    #1;
    check_outputs({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    check_outputs({tag, ".held"});
  endtask

  logic [WIDTH-1:0] hist [64];

  initial begin
    srst         = 1'b0;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    data_i       = '0;
    model_dout   = '0;

    // Reset before the first clock edge, with both enables high.
    #1 srst = 1'b1;
    #1;
    check_outputs("rst_async");
    cycle(1'b1, 1'b1, 6'h15, "rst_hold0");
    cycle(1'b1, 1'b1, 6'h2A, "rst_hold1");
    srst = 1'b0;

    // Fill with 0x01..0x08, then an ignored write while full.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, WIDTH'(i), "fill");
      check("fill.count_step", 32'(count), 32'(i));
    end
    check("fill.full", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, 6'h3F, "fill_over");
    check("fill_over.count", 32'(count), 32'd8);

    // Drain; data_o follows each read by one clock, then holds.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0, "drain");
      check("drain.order", 32'(data_o), 32'(i));
    end
    check("drain.empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, '0, "drain_under0");
    cycle(1'b0, 1'b1, '0, "drain_under1");
    check("drain_under.hold", 32'(data_o), 32'h08);

    // Streaming: both enables high for long enough to wrap the pointers.
    for (int i = 0; i < 24; i++) begin
      hist[i] = WIDTH'($urandom_range(0, 63));
      cycle(1'b1, 1'b1, hist[i], "stream");
      if (i >= 1) begin
        check("stream.delay", 32'(data_o), 32'(hist[i-1]));
        check("stream.count", 32'(count), 32'd1);
      end
    end
    cycle(1'b0, 1'b1, '0, "stream_flush");

    // Full with both enables: read happens, write is refused.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 1'b0, WIDTH'($urandom_range(0, 63)), "refill");
    cycle(1'b1, 1'b1, 6'h3C, "full_both");
    check("full_both.count", 32'(count), 32'd7);

    // Empty with both enables: write happens, read is refused.
    for (int i = 0; i < DEPTH - 1; i++)
      cycle(1'b0, 1'b1, '0, "redrain");
    check("redrain.empty", 32'(empty), 32'd1);
    hist[0] = data_o;
    cycle(1'b1, 1'b1, 6'h11, "empty_both");
    check("empty_both.count", 32'(count), 32'd1);
    check("empty_both.data_hold", 32'(data_o), 32'(hist[0]));
    cycle(1'b0, 1'b1, '0, "empty_both_rd");

    // Random mix of enables and data.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom_range(0, 63)), "random");

    // Mid-run reset with five words stored; first post-reset word reads back.
    while (model_q.size() > 0) cycle(1'b0, 1'b1, '0, "pre_rst_drain");
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, WIDTH'($urandom_range(0, 63)), "pre_rst_fill");
    check("pre_rst.count", 32'(count), 32'd5);
    reset_pulse("mid_rst");
    cycle(1'b1, 1'b0, 6'h2A, "post_rst_wr");
    cycle(1'b0, 1'b1, '0, "post_rst_rd");
    check("post_rst.data", 32'(data_o), 32'h2A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
